// File: rtl/tx_access_pkg.sv
// Shared types and constants for the tx access controller.
package tx_access_pkg;

  localparam int unsigned NUM_QUEUE       = 4;
  localparam int unsigned ACK_TIMER_WIDTH = 10;
  localparam int unsigned QIDX_WIDTH      = 2;
  localparam int unsigned CW_WIDTH        = 4;
  localparam int unsigned RETRY_WIDTH     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StTx,
    StAckWait
  } state_e;

  // One retry step of the contention-window exponent, saturating at cw_max.
  function automatic logic [CW_WIDTH-1:0] cw_step(input logic [CW_WIDTH-1:0] cur,
                                                  input logic [CW_WIDTH-1:0] cmin,
                                                  input logic [CW_WIDTH-1:0] cmax);
    if (cmin > cmax) return cmin;
    if (cur >= cmax) return cmax;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant search starting at last+1.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    cand      = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tx_access_ctrl.sv
// Channel access controller: queue grant, ACK wait, retry and CW exponent control.
// Define TX_ACCESS_CW_DOUBLING_EN to grow the CW exponent on each retry.
module tx_access_ctrl #(
  parameter int unsigned NUM_QUEUE       = tx_access_pkg::NUM_QUEUE,
  parameter int unsigned ACK_TIMER_WIDTH = tx_access_pkg::ACK_TIMER_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       tsf_pulse_1M,
  input  logic [NUM_QUEUE-1:0]       high_tx_allowed,
  input  logic [NUM_QUEUE-1:0]       queue_nonempty,
  output logic                       tx_start,
  output logic [1:0]                 tx_queue_idx,
  input  logic                       ack_required,
  input  logic                       tx_done,
  input  logic                       ack_rx_strobe,
  input  logic [ACK_TIMER_WIDTH-1:0] ack_timeout_time,
  input  logic [3:0]                 retry_limit,
  input  logic [3:0]                 cw_min,
  input  logic [3:0]                 cw_max,
  output logic [3:0]                 cw_exp,
  output logic                       tx_ok,
  output logic                       tx_fail,
  output logic                       busy
);

  import tx_access_pkg::*;

  state_e                     state_q;
  logic [ACK_TIMER_WIDTH-1:0] timer_q;
  logic [RETRY_WIDTH-1:0]     retry_cnt_q;
  logic                       retry_pend_q;
  logic                       ack_req_q;
  logic [1:0]                 last_grant_q;

  logic [NUM_QUEUE-1:0] eligible;
  logic                 gnt_valid;
  logic [1:0]           gnt_idx;
  logic                 ack_eff;
  logic                 timeout;
  logic                 in_ack;
  logic                 ack_go;
  logic                 retry_go;
  logic                 fail_go;

  // A pending retry pins eligibility to the queue that is still being served.
  always_comb begin
    eligible = high_tx_allowed & queue_nonempty;
    if (retry_pend_q) eligible &= ({{(NUM_QUEUE-1){1'b0}}, 1'b1} << tx_queue_idx);
  end

  rr_arbiter4 u_arb (
    .req       (eligible),
    .last      (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // ack_required is only valid in the tx_start cycle; cover tx_done landing there too.
  assign ack_eff  = tx_start ? ack_required : ack_req_q;
  assign timeout  = (timer_q == ack_timeout_time);
  assign in_ack   = (state_q == StAckWait);
  assign ack_go   = in_ack & ack_rx_strobe;
  assign retry_go = in_ack & ~ack_rx_strobe & timeout & (retry_cnt_q < retry_limit);
  assign fail_go  = in_ack & ~ack_rx_strobe & timeout & ~(retry_cnt_q < retry_limit);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
      ack_req_q    <= 1'b0;
      last_grant_q <= 2'd3;
      tx_start     <= 1'b0;
      tx_queue_idx <= 2'd0;
      tx_ok        <= 1'b0;
      tx_fail      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      tx_ok    <= 1'b0;
      tx_fail  <= 1'b0;
      if (tx_start) ack_req_q <= ack_required;
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            tx_start     <= 1'b1;
            tx_queue_idx <= gnt_idx;
            last_grant_q <= gnt_idx;
            busy         <= 1'b1;
            state_q      <= StTx;
          end
        end
        StTx: begin
          if (tx_done) begin
            if (ack_eff) begin
              timer_q <= '0;
              state_q <= StAckWait;
            end else begin
              tx_ok   <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StAckWait: begin
          if (tsf_pulse_1M) timer_q <= timer_q + 1'b1;
          if (ack_go || fail_go) begin
            tx_ok        <= ack_go;
            tx_fail      <= fail_go;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end else if (retry_go) begin
            retry_cnt_q  <= retry_cnt_q + 1'b1;
            retry_pend_q <= 1'b1;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef TX_ACCESS_CW_DOUBLING_EN
  logic [CW_WIDTH-1:0] cw_q;

  always_ff @(posedge clk) begin
    if (!rstn || ack_go || fail_go) cw_q <= cw_min;
    else if (retry_go)              cw_q <= cw_step(cw_q, cw_min, cw_max);
  end

  assign cw_exp = (cw_min > cw_max) ? cw_min : cw_q;
`else
  logic unused_cw_max;
  assign unused_cw_max = ^cw_max;
  assign cw_exp        = cw_min;
`endif

endmodule
